// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous RAM between instruction fetch (I) and load/store (D).
// Optional statistics counters are enabled with the ARB_STATS_EN macro.
module mem_port_arbiter #(
  parameter int AWIDTH   = 12,
  parameter int DWIDTH   = 32,
  parameter int READ_LAT = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DWIDTH-1:0] i_rdata,
  input  logic              d_req,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DWIDTH-1:0] d_rdata,
`ifdef ARB_STATS_EN
  output logic [31:0]       conflict_cnt,
  output logic [15:0]       starve_force_cnt,
`endif
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0] starve_cnt;
  owner_t     own_pipe [READ_LAT];
  owner_t     own_next;
  logic       force_i;

  always_comb begin
    force_i  = 1'b0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 4'h0;
    mem_addr = d_addr;
    mem_din  = '0;
    own_next = OWN_NONE;
    if (!rst) begin
      force_i = i_req && d_req && (starve_cnt == MAX_W);
      i_gnt   = i_req && (!d_req || force_i);
      d_gnt   = d_req && !i_gnt;
    end
    if (i_gnt) begin
      mem_en   = 1'b1;
      mem_addr = i_addr;
      own_next = OWN_I;
    end else if (d_gnt) begin
      mem_en   = 1'b1;
      mem_we   = d_we;
      mem_din  = d_wdata;
      own_next = (d_we == 4'h0) ? OWN_D : OWN_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!i_req || i_gnt) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt < MAX_W) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Ownership travels alongside the read so returned data lands on the right port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < READ_LAT; k++) own_pipe[k] <= OWN_NONE;
    end else begin
      own_pipe[0] <= own_next;
      for (int k = 1; k < READ_LAT; k++) own_pipe[k] <= own_pipe[k-1];
    end
  end

  assign i_rvalid = (own_pipe[READ_LAT-1] == OWN_I);
  assign d_rvalid = (own_pipe[READ_LAT-1] == OWN_D);
  assign i_rdata  = mem_dout;
  assign d_rdata  = mem_dout;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt     <= '0;
      starve_force_cnt <= '0;
    end else begin
      if (i_req && d_req) conflict_cnt <= conflict_cnt + 32'd1;
      if (force_i) starve_force_cnt <= starve_force_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (READ_LAT=1 and READ_LAT=2) share stimulus,
// each backed by its own behavioural RAM.
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_req, d_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [3:0]    d_we;
  logic [DW-1:0] d_wdata;

  logic          g1_i, g1_d, rv1_i, rv1_d, en1;
  logic [DW-1:0] rd1_i, rd1_d, din1, dout1;
  logic [3:0]    we1;
  logic [AW-1:0] addr1;
  logic          g2_i, g2_d, rv2_i, rv2_d, en2;
  logic [DW-1:0] rd2_i, rd2_d, din2, dout2;
  logic [3:0]    we2;
  logic [AW-1:0] addr2;
`ifdef ARB_STATS_EN
  logic [31:0] cc1, cc2;
  logic [15:0] sf1, sf2;
`endif

  mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .READ_LAT(1), .MAX_WAIT(3)) u1 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(g1_i), .i_rvalid(rv1_i), .i_rdata(rd1_i),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(g1_d), .d_rvalid(rv1_d), .d_rdata(rd1_d),
`ifdef ARB_STATS_EN
    .conflict_cnt(cc1), .starve_force_cnt(sf1),
`endif
    .mem_en(en1), .mem_we(we1), .mem_addr(addr1), .mem_din(din1), .mem_dout(dout1));

  mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .READ_LAT(2), .MAX_WAIT(3)) u2 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(g2_i), .i_rvalid(rv2_i), .i_rdata(rd2_i),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(g2_d), .d_rvalid(rv2_d), .d_rdata(rd2_d),
`ifdef ARB_STATS_EN
    .conflict_cnt(cc2), .starve_force_cnt(sf2),
`endif
    .mem_en(en2), .mem_we(we2), .mem_addr(addr2), .mem_din(din2), .mem_dout(dout2));

  // Behavioural RAMs: latency 1 and latency 2
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] mem2 [0:(1<<AW)-1];
  logic [DW-1:0] p2a, p2b;

  always @(posedge clk) begin
    if (en1) begin
      if (we1 != 4'h0) begin
        for (int b = 0; b < 4; b++) if (we1[b]) mem1[addr1][8*b +: 8] <= din1[8*b +: 8];
      end else dout1 <= mem1[addr1];
    end
  end

  always @(posedge clk) begin
    p2b <= p2a;
    if (en2) begin
      if (we2 != 4'h0) begin
        for (int b = 0; b < 4; b++) if (we2[b]) mem2[addr2][8*b +: 8] <= din2[8*b +: 8];
      end else p2a <= mem2[addr2];
    end
  end
  assign dout2 = p2b;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic ir, input logic [AW-1:0] ia, input logic dr,
                     input logic [AW-1:0] da, input logic [3:0] we, input logic [DW-1:0] wd);
    @(negedge clk);
    i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_we = we; d_wdata = wd;
    #1;
  endtask

  typedef struct {
    logic          ir;
    logic [AW-1:0] ia;
    logic          dr;
    logic [AW-1:0] da;
    logic [3:0]    dwe;
    logic [DW-1:0] dwd;
    logic          eig;
    logic          edg;
    logic [AW-1:0] eaddr;
  } vec_t;

  vec_t v [14];
  logic          e_en;
  logic [3:0]    e_we;
  logic [AW-1:0] e_ad;
  logic [1:0]    seq_f [5];

  initial begin
    v[0]  = '{1'b0, 12'h000, 1'b0, 12'h000, 4'h0, 32'h0,        1'b0, 1'b0, 12'h000};
    v[1]  = '{1'b1, 12'h010, 1'b0, 12'h000, 4'h0, 32'h0,        1'b1, 1'b0, 12'h010};
    v[2]  = '{1'b0, 12'h000, 1'b1, 12'h020, 4'h0, 32'h0,        1'b0, 1'b1, 12'h020};
    v[3]  = '{1'b0, 12'h000, 1'b1, 12'h070, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 12'h070};
    v[4]  = '{1'b1, 12'h030, 1'b1, 12'h050, 4'hF, 32'h12345678, 1'b0, 1'b1, 12'h050};
    v[5]  = '{1'b1, 12'h030, 1'b1, 12'h050, 4'hF, 32'h12345678, 1'b0, 1'b1, 12'h050};
    v[6]  = '{1'b1, 12'h030, 1'b1, 12'h050, 4'hF, 32'h12345678, 1'b0, 1'b1, 12'h050};
    v[7]  = '{1'b1, 12'h030, 1'b1, 12'h050, 4'hF, 32'h12345678, 1'b1, 1'b0, 12'h030};
    v[8]  = '{1'b1, 12'h030, 1'b1, 12'h050, 4'hF, 32'h12345678, 1'b0, 1'b1, 12'h050};
    v[9]  = '{1'b1, 12'h031, 1'b0, 12'h000, 4'h0, 32'h0,        1'b1, 1'b0, 12'h031};
    v[10] = '{1'b1, 12'h032, 1'b1, 12'h060, 4'h3, 32'h5555AAAA, 1'b0, 1'b1, 12'h060};
    v[11] = '{1'b0, 12'h000, 1'b1, 12'h061, 4'h0, 32'h0,        1'b0, 1'b1, 12'h061};
    v[12] = '{1'b1, 12'h033, 1'b1, 12'h062, 4'h0, 32'h0,        1'b0, 1'b1, 12'h062};
    v[13] = '{1'b0, 12'h000, 1'b0, 12'h000, 4'h0, 32'h0,        1'b0, 1'b0, 12'h000};

    // Reset state, with both requests asserted
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0; d_we = 4'h0; d_wdata = '0;
    @(negedge clk);
    i_req = 1'b1; d_req = 1'b1;
    #1;
    chk("reset_u1", {g1_i, g1_d, en1, we1, rv1_i, rv1_d}, 64'h0);
    chk("reset_u2", {g2_i, g2_d, en2, we2, rv2_i, rv2_d}, 64'h0);
    @(negedge clk);
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;

    for (int k = 0; k < 14; k++) begin
      cyc(v[k].ir, v[k].ia, v[k].dr, v[k].da, v[k].dwe, v[k].dwd);
      e_en = v[k].eig | v[k].edg;
      e_we = v[k].edg ? v[k].dwe : 4'h0;
      e_ad = e_en ? v[k].eaddr : '0;
      chk($sformatf("vec%0d_u1", k), {g1_i, g1_d, en1, we1, (en1 ? addr1 : 12'h0)},
          {v[k].eig, v[k].edg, e_en, e_we, e_ad});
      chk($sformatf("vec%0d_u2", k), {g2_i, g2_d, en2, we2, (en2 ? addr2 : 12'h0)},
          {v[k].eig, v[k].edg, e_en, e_we, e_ad});
      if (v[k].edg && v[k].dwe != 4'h0) chk($sformatf("vec%0d_din", k), din1, v[k].dwd);
    end

    // Preload through the D port, then a lone fetch on the latency-1 instance
    cyc(1'b0, 12'h0, 1'b1, 12'h010, 4'hF, 32'h00000013);
    cyc(1'b0, 12'h0, 1'b1, 12'h020, 4'hF, 32'h000000AA);
    cyc(1'b0, 12'h0, 1'b1, 12'h030, 4'hF, 32'h000000BB);
    cyc(1'b0, 12'h0, 1'b0, 12'h0, 4'h0, 32'h0);
    cyc(1'b0, 12'h0, 1'b0, 12'h0, 4'h0, 32'h0);
    cyc(1'b1, 12'h010, 1'b0, 12'h0, 4'h0, 32'h0);
    chk("fetch_gnt", {g1_i, g1_d, en1, addr1}, {1'b1, 1'b0, 1'b1, 12'h010});
    cyc(1'b0, 12'h0, 1'b0, 12'h0, 4'h0, 32'h0);
    chk("fetch_ret", {rv1_i, rd1_i, rv1_d}, {1'b1, 32'h00000013, 1'b0});
    cyc(1'b0, 12'h0, 1'b0, 12'h0, 4'h0, 32'h0);
    chk("fetch_once", {rv1_i, rv1_d}, 64'h0);

    // Pipelined D read, I read, D write on the latency-2 instance
    cyc(1'b0, 12'h0, 1'b1, 12'h020, 4'h0, 32'h0);
    cyc(1'b1, 12'h030, 1'b0, 12'h0, 4'h0, 32'h0);
    chk("pipe_u1_d", {rv1_d, rd1_d, rv1_i}, {1'b1, 32'h000000AA, 1'b0});
    cyc(1'b0, 12'h0, 1'b1, 12'h040, 4'hF, 32'h0000012C);
    chk("pipe_c2", {rv2_d, rd2_d, rv2_i}, {1'b1, 32'h000000AA, 1'b0});
    cyc(1'b0, 12'h0, 1'b0, 12'h0, 4'h0, 32'h0);
    chk("pipe_c3", {rv2_i, rd2_i, rv2_d}, {1'b1, 32'h000000BB, 1'b0});
    cyc(1'b0, 12'h0, 1'b0, 12'h0, 4'h0, 32'h0);
    chk("pipe_c4", {rv2_i, rv2_d}, 64'h0);
    chk("pipe_wr", {mem1[12'h040], mem2[12'h040]}, {32'h0000012C, 32'h0000012C});

    // Reset one cycle after an I read grant
    cyc(1'b1, 12'h030, 1'b0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_u2", {g2_i, g2_d, en2, we2, rv2_i, rv2_d}, 64'h0);
    chk("rst_async_u1", {g1_i, g1_d, en1, we1, rv1_i, rv1_d}, 64'h0);
    @(negedge clk);
    rst = 1'b0; i_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 12'h0, 1'b0, 12'h0, 4'h0, 32'h0);
      chk($sformatf("rst_drop%0d", k), {rv1_i, rv1_d, rv2_i, rv2_d}, 64'h0);
    end

    // Idle stretch
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 12'h0, 1'b0, 12'h0, 4'h0, 32'h0);
      chk($sformatf("idle%0d", k), {en1, en2, rv1_i, rv1_d, rv2_i, rv2_d}, 64'h0);
    end

    // Five contested cycles: D,D,D,I,D (2'b01 = D, 2'b10 = I)
    seq_f[0] = 2'b01; seq_f[1] = 2'b01; seq_f[2] = 2'b01; seq_f[3] = 2'b10; seq_f[4] = 2'b01;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 12'h100, 1'b1, 12'h200, 4'h0, 32'h0);
      chk($sformatf("contest%0d_u1", k), {g1_i, g1_d}, {62'h0, seq_f[k]});
      chk($sformatf("contest%0d_u2", k), {g2_i, g2_d}, {62'h0, seq_f[k]});
    end
    cyc(1'b0, 12'h0, 1'b0, 12'h0, 4'h0, 32'h0);
`ifdef ARB_STATS_EN
    chk("stats_u1", {cc1, sf1}, {32'd5, 16'd1});
    chk("stats_u2", {cc2, sf2}, {32'd5, 16'd1});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
